// File: rtl/store_buffer_fwd.sv
// -----------------------------------------------------------------------------
// store_buffer_fwd
//
// Two-level store buffer with store-to-load forwarding.
//
// Stores enter a speculative FIFO. A commit moves the oldest speculative store
// into a committed FIFO, which drains into the D$ write port. A flush discards
// every speculative store but leaves committed stores alone. Loads probe both
// FIFOs combinationally. Each requested byte comes from the youngest matching
// store that writes it.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                drop all speculative stores
//   valid_i / ready_o      store enqueue handshake
//   paddr_i, data_i,       enqueued store: address, data, byte enables, size
//   be_i, size_i
//   commit_i /             promote the oldest speculative store
//   commit_ready_o
//   fwd_paddr_i, fwd_be_i  load forwarding probe
//   fwd_data_o,            forwarded bytes (uncovered bytes zero), covered
//   fwd_hit_be_o,          byte mask, all-requested-bytes-covered flag
//   fwd_full_o
//   no_st_pending_o        committed FIFO empty
//   empty_o                both FIFOs empty
//   stall_i                hold off D$ requests
//   req_o, gnt_i,          D$ write request taken from the committed head
//   req_addr_o, req_data_o,
//   req_be_o, req_size_o
// -----------------------------------------------------------------------------
module store_buffer_fwd #(
   parameter int XLEN         = 64,
   parameter int PLEN         = 56,
   parameter int DEPTH_SPEC   = 8,
   parameter int DEPTH_COMMIT = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [PLEN-1:0]   paddr_i,
   input  logic [XLEN-1:0]   data_i,
   input  logic [XLEN/8-1:0] be_i,
   input  logic [1:0]        size_i,
   input  logic              commit_i,
   output logic              commit_ready_o,
   input  logic [PLEN-1:0]   fwd_paddr_i,
   input  logic [XLEN/8-1:0] fwd_be_i,
   output logic [XLEN-1:0]   fwd_data_o,
   output logic [XLEN/8-1:0] fwd_hit_be_o,
   output logic              fwd_full_o,
   output logic              no_st_pending_o,
   output logic              empty_o,
   input  logic              stall_i,
   output logic              req_o,
   input  logic              gnt_i,
   output logic [PLEN-1:0]   req_addr_o,
   output logic [XLEN-1:0]   req_data_o,
   output logic [XLEN/8-1:0] req_be_o,
   output logic [1:0]        req_size_o
);

   localparam int BEW  = XLEN / 8;
   localparam int OFFW = $clog2(BEW);
   localparam int SPW  = $clog2(DEPTH_SPEC);
   localparam int SCW  = SPW + 1;
   localparam int CPW  = $clog2(DEPTH_COMMIT);
   localparam int CCW  = CPW + 1;

   localparam logic [SCW-1:0] SPEC_DEPTH_C = SCW'(DEPTH_SPEC);
   localparam logic [CCW-1:0] CMT_DEPTH_C  = CCW'(DEPTH_COMMIT);

   // ---------------------------------------------------------------------------
   // Control state (reset) and entry payload (not reset)
   // ---------------------------------------------------------------------------
   logic [SPW-1:0]        spec_rd_q, spec_rd_d;
   logic [SPW-1:0]        spec_wr_q, spec_wr_d;
   logic [SCW-1:0]        spec_cnt_q, spec_cnt_d;
   logic [DEPTH_SPEC-1:0] spec_vld_q, spec_vld_d;

   logic [CPW-1:0]          cmt_rd_q, cmt_rd_d;
   logic [CPW-1:0]          cmt_wr_q, cmt_wr_d;
   logic [CCW-1:0]          cmt_cnt_q, cmt_cnt_d;
   logic [DEPTH_COMMIT-1:0] cmt_vld_q, cmt_vld_d;

   logic [PLEN-1:0] spec_addr_q [DEPTH_SPEC];
   logic [PLEN-1:0] spec_addr_d [DEPTH_SPEC];
   logic [XLEN-1:0] spec_data_q [DEPTH_SPEC];
   logic [XLEN-1:0] spec_data_d [DEPTH_SPEC];
   logic [BEW-1:0]  spec_be_q   [DEPTH_SPEC];
   logic [BEW-1:0]  spec_be_d   [DEPTH_SPEC];
   logic [1:0]      spec_size_q [DEPTH_SPEC];
   logic [1:0]      spec_size_d [DEPTH_SPEC];

   logic [PLEN-1:0] cmt_addr_q [DEPTH_COMMIT];
   logic [PLEN-1:0] cmt_addr_d [DEPTH_COMMIT];
   logic [XLEN-1:0] cmt_data_q [DEPTH_COMMIT];
   logic [XLEN-1:0] cmt_data_d [DEPTH_COMMIT];
   logic [BEW-1:0]  cmt_be_q   [DEPTH_COMMIT];
   logic [BEW-1:0]  cmt_be_d   [DEPTH_COMMIT];
   logic [1:0]      cmt_size_q [DEPTH_COMMIT];
   logic [1:0]      cmt_size_d [DEPTH_COMMIT];

   logic enq_acc;
   logic cmt_acc;
   logic drain_pop;

   // Low offset bits of the probe address never take part in the word match.
   logic unused_fwd_off;
   assign unused_fwd_off = ^fwd_paddr_i;

   // ---------------------------------------------------------------------------
   // Handshakes and status, all from registered state
   // ---------------------------------------------------------------------------
   assign ready_o         = (spec_cnt_q < SPEC_DEPTH_C);
   assign commit_ready_o  = (cmt_cnt_q < CMT_DEPTH_C) && (spec_cnt_q != '0);
   assign req_o           = (cmt_cnt_q != '0) && !stall_i;
   assign no_st_pending_o = (cmt_cnt_q == '0);
   assign empty_o         = (cmt_cnt_q == '0) && (spec_cnt_q == '0);

   assign req_addr_o = cmt_addr_q[cmt_rd_q];
   assign req_data_o = cmt_data_q[cmt_rd_q];
   assign req_be_o   = cmt_be_q[cmt_rd_q];
   assign req_size_o = cmt_size_q[cmt_rd_q];

   assign enq_acc   = valid_i && ready_o && !flush_i;
   assign cmt_acc   = commit_i && commit_ready_o;
   assign drain_pop = req_o && gnt_i;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      spec_rd_d   = spec_rd_q;
      spec_wr_d   = spec_wr_q;
      spec_cnt_d  = spec_cnt_q;
      spec_vld_d  = spec_vld_q;
      cmt_rd_d    = cmt_rd_q;
      cmt_wr_d    = cmt_wr_q;
      cmt_cnt_d   = cmt_cnt_q;
      cmt_vld_d   = cmt_vld_q;
      spec_addr_d = spec_addr_q;
      spec_data_d = spec_data_q;
      spec_be_d   = spec_be_q;
      spec_size_d = spec_size_q;
      cmt_addr_d  = cmt_addr_q;
      cmt_data_d  = cmt_data_q;
      cmt_be_d    = cmt_be_q;
      cmt_size_d  = cmt_size_q;

      // Drain pop and commit push never target the same slot: a commit needs a
      // non-full committed FIFO, so tail and head differ whenever both occur.
      if (drain_pop) begin
         cmt_vld_d[cmt_rd_q] = 1'b0;
         cmt_rd_d            = cmt_rd_q + CPW'(1);
      end

      if (cmt_acc) begin
         cmt_addr_d[cmt_wr_q] = spec_addr_q[spec_rd_q];
         cmt_data_d[cmt_wr_q] = spec_data_q[spec_rd_q];
         cmt_be_d[cmt_wr_q]   = spec_be_q[spec_rd_q];
         cmt_size_d[cmt_wr_q] = spec_size_q[spec_rd_q];
         cmt_vld_d[cmt_wr_q]  = 1'b1;
         cmt_wr_d             = cmt_wr_q + CPW'(1);
         spec_vld_d[spec_rd_q] = 1'b0;
         spec_rd_d            = spec_rd_q + SPW'(1);
      end

      if (enq_acc) begin
         spec_addr_d[spec_wr_q] = paddr_i;
         spec_data_d[spec_wr_q] = data_i;
         spec_be_d[spec_wr_q]   = be_i;
         spec_size_d[spec_wr_q] = size_i;
         spec_vld_d[spec_wr_q]  = 1'b1;
         spec_wr_d              = spec_wr_q + SPW'(1);
      end

      case ({enq_acc, cmt_acc})
         2'b10:   spec_cnt_d = spec_cnt_q + SCW'(1);
         2'b01:   spec_cnt_d = spec_cnt_q - SCW'(1);
         default: spec_cnt_d = spec_cnt_q;
      endcase

      case ({cmt_acc, drain_pop})
         2'b10:   cmt_cnt_d = cmt_cnt_q + CCW'(1);
         2'b01:   cmt_cnt_d = cmt_cnt_q - CCW'(1);
         default: cmt_cnt_d = cmt_cnt_q;
      endcase

      // The commit above has already advanced the read pointer, so the flush
      // drops only what is left behind the promoted store.
      if (flush_i) begin
         spec_vld_d = '0;
         spec_wr_d  = spec_rd_d;
         spec_cnt_d = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Forwarding: walk oldest to youngest, later matches overwrite earlier ones
   // ---------------------------------------------------------------------------
   always_comb begin
      logic [BEW-1:0]  cov;
      logic [XLEN-1:0] raw;
      logic [CPW-1:0]  cidx;
      logic [SPW-1:0]  sidx;

      cov  = '0;
      raw  = '0;
      cidx = '0;
      sidx = '0;

      for (int i = 0; i < DEPTH_COMMIT; i++) begin
         cidx = cmt_rd_q + CPW'(i);
         if (cmt_vld_q[cidx] &&
             (cmt_addr_q[cidx][PLEN-1:OFFW] == fwd_paddr_i[PLEN-1:OFFW])) begin
            for (int b = 0; b < BEW; b++) begin
               if (cmt_be_q[cidx][b]) begin
                  cov[b]       = 1'b1;
                  raw[8*b +: 8] = cmt_data_q[cidx][8*b +: 8];
               end
            end
         end
      end

      for (int i = 0; i < DEPTH_SPEC; i++) begin
         sidx = spec_rd_q + SPW'(i);
         if (spec_vld_q[sidx] &&
             (spec_addr_q[sidx][PLEN-1:OFFW] == fwd_paddr_i[PLEN-1:OFFW])) begin
            for (int b = 0; b < BEW; b++) begin
               if (spec_be_q[sidx][b]) begin
                  cov[b]       = 1'b1;
                  raw[8*b +: 8] = spec_data_q[sidx][8*b +: 8];
               end
            end
         end
      end

      fwd_hit_be_o = cov & fwd_be_i;
      fwd_data_o   = '0;
      for (int b = 0; b < BEW; b++) begin
         if (fwd_hit_be_o[b]) fwd_data_o[8*b +: 8] = raw[8*b +: 8];
      end
      fwd_full_o = (fwd_hit_be_o == fwd_be_i) && (fwd_be_i != '0);
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         spec_rd_q  <= '0;
         spec_wr_q  <= '0;
         spec_cnt_q <= '0;
         spec_vld_q <= '0;
         cmt_rd_q   <= '0;
         cmt_wr_q   <= '0;
         cmt_cnt_q  <= '0;
         cmt_vld_q  <= '0;
      end else begin
         spec_rd_q  <= spec_rd_d;
         spec_wr_q  <= spec_wr_d;
         spec_cnt_q <= spec_cnt_d;
         spec_vld_q <= spec_vld_d;
         cmt_rd_q   <= cmt_rd_d;
         cmt_wr_q   <= cmt_wr_d;
         cmt_cnt_q  <= cmt_cnt_d;
         cmt_vld_q  <= cmt_vld_d;
      end
   end

   // Payload is qualified by the valid bits, so it needs no reset.
   always_ff @(posedge clk_i) begin
      spec_addr_q <= spec_addr_d;
      spec_data_q <= spec_data_d;
      spec_be_q   <= spec_be_d;
      spec_size_q <= spec_size_d;
      cmt_addr_q  <= cmt_addr_d;
      cmt_data_q  <= cmt_data_d;
      cmt_be_q    <= cmt_be_d;
      cmt_size_q  <= cmt_size_d;
   end

endmodule

// File: tb/tb_store_buffer_fwd.sv
module tb_store_buffer_fwd;
   localparam int XLEN = 64;
   localparam int PLEN = 56;
   localparam int BEW  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n, flush, valid, commit, stall, gnt;
   logic [PLEN-1:0] paddr, fwd_paddr;
   logic [XLEN-1:0] data;
   logic [BEW-1:0]  be, fwd_be;
   logic [1:0]      size;

   logic a_ready, a_cready, a_full, a_nsp, a_empty, a_req;
   logic b_ready, b_cready, b_full, b_nsp, b_empty, b_req;
   logic [XLEN-1:0] a_fdata, a_rdata, b_fdata, b_rdata;
   logic [BEW-1:0]  a_hit, a_rbe, b_hit, b_rbe;
   logic [PLEN-1:0] a_raddr, b_raddr;
   logic [1:0]      a_rsize, b_rsize;

   store_buffer_fwd #(.XLEN(XLEN), .PLEN(PLEN), .DEPTH_SPEC(8), .DEPTH_COMMIT(8)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(a_ready),
      .paddr_i(paddr), .data_i(data), .be_i(be), .size_i(size),
      .commit_i(commit), .commit_ready_o(a_cready),
      .fwd_paddr_i(fwd_paddr), .fwd_be_i(fwd_be), .fwd_data_o(a_fdata),
      .fwd_hit_be_o(a_hit), .fwd_full_o(a_full),
      .no_st_pending_o(a_nsp), .empty_o(a_empty), .stall_i(stall),
      .req_o(a_req), .gnt_i(gnt), .req_addr_o(a_raddr), .req_data_o(a_rdata),
      .req_be_o(a_rbe), .req_size_o(a_rsize));

   store_buffer_fwd #(.XLEN(XLEN), .PLEN(PLEN), .DEPTH_SPEC(4), .DEPTH_COMMIT(4)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(b_ready),
      .paddr_i(paddr), .data_i(data), .be_i(be), .size_i(size),
      .commit_i(commit), .commit_ready_o(b_cready),
      .fwd_paddr_i(fwd_paddr), .fwd_be_i(fwd_be), .fwd_data_o(b_fdata),
      .fwd_hit_be_o(b_hit), .fwd_full_o(b_full),
      .no_st_pending_o(b_nsp), .empty_o(b_empty), .stall_i(stall),
      .req_o(b_req), .gnt_i(gnt), .req_addr_o(b_raddr), .req_data_o(b_rdata),
      .req_be_o(b_rbe), .req_size_o(b_rsize));

   // Outputs of the instance under test in the current section
   logic sel_b;
   logic s_ready, s_cready, s_full, s_nsp, s_empty, s_req;
   logic [XLEN-1:0] s_fdata, s_rdata;
   logic [BEW-1:0]  s_hit, s_rbe;
   logic [PLEN-1:0] s_raddr;
   logic [1:0]      s_rsize;
   assign s_ready  = sel_b ? b_ready  : a_ready;
   assign s_cready = sel_b ? b_cready : a_cready;
   assign s_full   = sel_b ? b_full   : a_full;
   assign s_nsp    = sel_b ? b_nsp    : a_nsp;
   assign s_empty  = sel_b ? b_empty  : a_empty;
   assign s_req    = sel_b ? b_req    : a_req;
   assign s_fdata  = sel_b ? b_fdata  : a_fdata;
   assign s_rdata  = sel_b ? b_rdata  : a_rdata;
   assign s_hit    = sel_b ? b_hit    : a_hit;
   assign s_rbe    = sel_b ? b_rbe    : a_rbe;
   assign s_raddr  = sel_b ? b_raddr  : a_raddr;
   assign s_rsize  = sel_b ? b_rsize  : a_rsize;

   typedef struct packed {
      logic [PLEN-1:0] addr;
      logic [XLEN-1:0] data;
      logic [BEW-1:0]  be;
      logic [1:0]      size;
   } st_t;

   typedef struct {
      logic v; logic [PLEN-1:0] a; logic [XLEN-1:0] d; logic [BEW-1:0] be; logic [1:0] sz;
      logic c; logic fl; logic st; logic g; logic [PLEN-1:0] fa; logic [BEW-1:0] fbe;
      logic hand;
      logic e_ready, e_cready, e_req, e_nsp, e_empty, e_full;
      logic [BEW-1:0] e_hit; logic [XLEN-1:0] e_fdata;
   } vec_t;

   st_t sq[$];
   st_t cq[$];
   int  mdepth;
   int  tests = 0;
   int  fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(logic v, logic [PLEN-1:0] a, logic [XLEN-1:0] d, logic [BEW-1:0] b,
                               logic c, logic st, logic g, logic [PLEN-1:0] fa, logic [BEW-1:0] fbe);
      vec_t r;
      r.v = v; r.a = a; r.d = d; r.be = b; r.sz = 2'd3; r.c = c; r.fl = 1'b0; r.st = st; r.g = g;
      r.fa = fa; r.fbe = fbe; r.hand = 1'b0;
      r.e_ready = 1'b0; r.e_cready = 1'b0; r.e_req = 1'b0; r.e_nsp = 1'b0; r.e_empty = 1'b0;
      r.e_full = 1'b0; r.e_hit = '0; r.e_fdata = '0;
      return r;
   endfunction

   function automatic vec_t ex(vec_t r, logic rdy, logic cr, logic rq, logic nsp, logic emp,
                               logic [BEW-1:0] hit, logic [XLEN-1:0] fd, logic full);
      vec_t o = r;
      o.hand = 1'b1; o.e_ready = rdy; o.e_cready = cr; o.e_req = rq; o.e_nsp = nsp;
      o.e_empty = emp; o.e_hit = hit; o.e_fdata = fd; o.e_full = full;
      return o;
   endfunction

   // Reference forwarding: committed oldest..youngest, then speculative.
   task automatic mfwd(input logic [PLEN-1:0] fa, input logic [BEW-1:0] fbe,
                       output logic [BEW-1:0] hit, output logic [XLEN-1:0] fd, output logic full);
      logic [BEW-1:0]  cov = '0;
      logic [XLEN-1:0] d = '0;
      foreach (cq[i]) if (cq[i].addr[PLEN-1:3] == fa[PLEN-1:3])
         for (int b = 0; b < BEW; b++) if (cq[i].be[b]) begin cov[b] = 1'b1; d[8*b +: 8] = cq[i].data[8*b +: 8]; end
      foreach (sq[i]) if (sq[i].addr[PLEN-1:3] == fa[PLEN-1:3])
         for (int b = 0; b < BEW; b++) if (sq[i].be[b]) begin cov[b] = 1'b1; d[8*b +: 8] = sq[i].data[8*b +: 8]; end
      hit = cov & fbe;
      fd  = '0;
      for (int b = 0; b < BEW; b++) if (hit[b]) fd[8*b +: 8] = d[8*b +: 8];
      full = (hit == fbe) && (fbe != '0);
   endtask

   // One clock: drive, check against the model (and hand values), update model.
   task automatic cyc(input vec_t r);
      logic m_ready, m_cr, m_req, mfull;
      logic [BEW-1:0]  mhit;
      logic [XLEN-1:0] mdat;
      st_t e;
      valid = r.v; paddr = r.a; data = r.d; be = r.be; size = r.sz; commit = r.c;
      flush = r.fl; stall = r.st; gnt = r.g; fwd_paddr = r.fa; fwd_be = r.fbe;
      #1;
      m_ready = (sq.size() < mdepth);
      m_cr    = (cq.size() < mdepth) && (sq.size() != 0);
      m_req   = (cq.size() != 0) && !r.st;
      mfwd(r.fa, r.fbe, mhit, mdat, mfull);
      chk("ready_o", s_ready, m_ready);
      chk("commit_ready_o", s_cready, m_cr);
      chk("req_o", s_req, m_req);
      chk("no_st_pending_o", s_nsp, cq.size() == 0);
      chk("empty_o", s_empty, (cq.size() == 0) && (sq.size() == 0));
      chk("fwd_hit_be_o", s_hit, mhit);
      chk("fwd_data_o", s_fdata, mdat);
      chk("fwd_full_o", s_full, mfull);
      if (r.hand) begin
         chk("vec ready_o", s_ready, r.e_ready);
         chk("vec commit_ready_o", s_cready, r.e_cready);
         chk("vec req_o", s_req, r.e_req);
         chk("vec no_st_pending_o", s_nsp, r.e_nsp);
         chk("vec empty_o", s_empty, r.e_empty);
         chk("vec fwd_hit_be_o", s_hit, r.e_hit);
         chk("vec fwd_data_o", s_fdata, r.e_fdata);
         chk("vec fwd_full_o", s_full, r.e_full);
      end
      if (m_req && r.g) begin
         e = cq.pop_front();
         chk("req_addr_o", s_raddr, e.addr);
         chk("req_data_o", s_rdata, e.data);
         chk("req_be_o", s_rbe, e.be);
         chk("req_size_o", s_rsize, e.size);
      end
      if (r.c && m_cr) cq.push_back(sq.pop_front());
      if (r.fl) sq.delete();
      if (r.v && m_ready && !r.fl) sq.push_back({r.a, r.d, r.be, r.sz});
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      valid = 1'b0; paddr = '0; data = '0; be = '0; size = '0; commit = 1'b0;
      flush = 1'b0; stall = 1'b1; gnt = 1'b0; fwd_paddr = '0; fwd_be = 8'hFF;
   endtask

   task automatic do_reset(input logic b);
      sel_b = b; mdepth = b ? 4 : 8;
      sq.delete(); cq.delete();
      idle_inputs();
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("reset ready_o", s_ready, 1'b1);
      chk("reset commit_ready_o", s_cready, 1'b0);
      chk("reset req_o", s_req, 1'b0);
      chk("reset no_st_pending_o", s_nsp, 1'b1);
      chk("reset empty_o", s_empty, 1'b1);
      chk("reset fwd_hit_be_o", s_hit, 8'h00);
      chk("reset fwd_full_o", s_full, 1'b0);
      chk("reset fwd_data_o", s_fdata, 64'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   localparam logic [63:0] DA = 64'hAAAAAAAA_AAAAAAAA;
   localparam logic [63:0] DB = 64'hBBBBBBBB_BBBBBBBB;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[13];
      vec_t r;

      // Forwarding table: committed 0x2000/FF/A.., speculative 0x2004/F0/B..
      tbl[0]  = ex(mk(0, 0,      0,  8'h00, 0, 1, 0, 56'h2000, 8'hFF), 1, 0, 0, 1, 1, 8'h00, 64'h0, 0);
      tbl[1]  = ex(mk(1, 56'h2000, DA, 8'hFF, 0, 1, 0, 56'h2000, 8'hFF), 1, 0, 0, 1, 1, 8'h00, 64'h0, 0);
      tbl[2]  = ex(mk(0, 0,      0,  8'h00, 1, 1, 0, 56'h2000, 8'hFF), 1, 1, 0, 1, 0, 8'hFF, DA, 1);
      tbl[3]  = ex(mk(1, 56'h2004, DB, 8'hF0, 0, 1, 0, 56'h2000, 8'hFF), 1, 0, 0, 0, 0, 8'hFF, DA, 1);
      tbl[4]  = ex(mk(0, 0,      0,  8'h00, 0, 1, 0, 56'h2000, 8'hFF), 1, 1, 0, 0, 0, 8'hFF,
                   64'hBBBBBBBB_AAAAAAAA, 1);
      tbl[5]  = ex(mk(0, 0,      0,  8'h00, 0, 1, 0, 56'h2000, 8'h0F), 1, 1, 0, 0, 0, 8'h0F,
                   64'h00000000_AAAAAAAA, 1);
      tbl[6]  = ex(mk(0, 0,      0,  8'h00, 0, 1, 0, 56'h2008, 8'hFF), 1, 1, 0, 0, 0, 8'h00, 64'h0, 0);
      tbl[7]  = ex(mk(0, 0,      0,  8'h00, 0, 1, 0, 56'h2000, 8'h00), 1, 1, 0, 0, 0, 8'h00, 64'h0, 0);
      tbl[8]  = ex(mk(0, 0,      0,  8'h00, 0, 0, 1, 56'h2000, 8'hFF), 1, 1, 1, 0, 0, 8'hFF,
                   64'hBBBBBBBB_AAAAAAAA, 1);
      tbl[9]  = ex(mk(0, 0,      0,  8'h00, 0, 0, 0, 56'h2000, 8'hFF), 1, 1, 0, 1, 0, 8'hF0,
                   64'hBBBBBBBB_00000000, 0);
      tbl[10] = ex(mk(0, 0,      0,  8'h00, 1, 0, 0, 56'h2000, 8'hFF), 1, 1, 0, 1, 0, 8'hF0,
                   64'hBBBBBBBB_00000000, 0);
      tbl[11] = ex(mk(0, 0,      0,  8'h00, 0, 0, 1, 56'h2000, 8'hFF), 1, 0, 1, 0, 0, 8'hF0,
                   64'hBBBBBBBB_00000000, 0);
      tbl[12] = ex(mk(0, 0,      0,  8'h00, 0, 0, 0, 56'h2000, 8'hFF), 1, 0, 0, 1, 1, 8'h00, 64'h0, 0);

      sel_b = 1'b0; mdepth = 8; rst_n = 1'b1;
      idle_inputs();
      @(posedge clk); #1;

      do_reset(1'b0);
      for (int i = 0; i < 13; i++) cyc(tbl[i]);

      // Fill to capacity; the ninth store is refused; enqueue+commit keeps the count.
      do_reset(1'b0);
      for (int i = 0; i < 8; i++)
         cyc(mk(1, 56'h5000 + 56'(8*i), 64'(i) * 64'h0101_0101_0101_0101, 8'hFF, 0, 1, 0, 56'h5000, 8'hFF));
      chk("full ready_o", s_ready, 1'b0);
      cyc(mk(1, 56'h6000, 64'h6666, 8'hFF, 0, 1, 0, 56'h6000, 8'hFF));
      cyc(mk(0, 0, 0, 8'h00, 1, 1, 0, 56'h5000, 8'hFF));
      cyc(mk(1, 56'h7000, 64'h7777, 8'hFF, 1, 1, 0, 56'h7000, 8'hFF));
      chk("enq+commit ready_o", s_ready, 1'b1);
      cyc(mk(1, 56'h7008, 64'h7788, 8'hFF, 0, 1, 0, 56'h7000, 8'hFF));
      chk("refilled ready_o", s_ready, 1'b0);
      for (int k = 0; k < 40 && (sq.size() != 0 || cq.size() != 0); k++)
         cyc(mk(0, 0, 0, 8'h00, 1, 0, 1, 56'h6000, 8'hFF));
      chk("fill drained empty_o", s_empty, 1'b1);

      // Single store through commit to the D$ port.
      do_reset(1'b0);
      r = mk(1, 56'h1000, 64'h11223344, 8'h0F, 0, 0, 1, 56'h1000, 8'h0F);
      r.sz = 2'd2;
      cyc(r);
      cyc(mk(0, 0, 0, 8'h00, 1, 0, 1, 56'h1000, 8'h0F));
      chk("single req_o", s_req, 1'b1);
      chk("single req_addr_o", s_raddr, 56'h1000);
      cyc(mk(0, 0, 0, 8'h00, 0, 0, 1, 56'h1000, 8'h0F));
      chk("single no_st_pending_o", s_nsp, 1'b1);

      // Flush together with a commit.
      do_reset(1'b0);
      cyc(mk(1, 56'h3000, 64'h3030_3030_3030_3030, 8'hFF, 0, 1, 0, 0, 8'hFF));
      cyc(mk(1, 56'h3008, 64'h3838_3838_3838_3838, 8'hFF, 0, 1, 0, 0, 8'hFF));
      cyc(mk(1, 56'h3010, 64'h3131_3131_3131_3131, 8'hFF, 0, 1, 0, 0, 8'hFF));
      r = mk(0, 0, 0, 8'h00, 1, 1, 0, 56'h3008, 8'hFF);
      r.fl = 1'b1;
      cyc(r);
      chk("flush commit_ready_o", s_cready, 1'b0);
      chk("flush no_st_pending_o", s_nsp, 1'b0);
      cyc(mk(0, 0, 0, 8'h00, 0, 1, 0, 56'h3008, 8'hFF));
      chk("flushed 0x3008 hit", s_hit, 8'h00);
      cyc(mk(0, 0, 0, 8'h00, 0, 1, 0, 56'h3010, 8'hFF));
      cyc(mk(0, 0, 0, 8'h00, 0, 1, 0, 56'h3000, 8'hFF));
      chk("kept 0x3000 hit", s_hit, 8'hFF);

      // Stall holds two committed stores, then two granted cycles drain them.
      do_reset(1'b0);
      cyc(mk(1, 56'h8000, 64'h8080, 8'hFF, 0, 1, 0, 0, 8'hFF));
      cyc(mk(1, 56'h8008, 64'h8888, 8'hFF, 1, 1, 0, 0, 8'hFF));
      cyc(mk(0, 0, 0, 8'h00, 1, 1, 1, 0, 8'hFF));
      cyc(mk(0, 0, 0, 8'h00, 0, 1, 1, 0, 8'hFF));
      chk("stall req_o", s_req, 1'b0);
      cyc(mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 8'hFF));
      cyc(mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 8'hFF));
      chk("drained empty_o", s_empty, 1'b1);

      // Reset while a request is up.
      do_reset(1'b0);
      cyc(mk(1, 56'h9000, 64'h9090, 8'hFF, 0, 1, 0, 0, 8'hFF));
      cyc(mk(1, 56'h9008, 64'h9898, 8'hFF, 1, 1, 0, 0, 8'hFF));
      cyc(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 8'hFF));
      stall = 1'b0; gnt = 1'b0; commit = 1'b0; #1;
      chk("pre-reset req_o", s_req, 1'b1);
      #1 rst_n = 1'b0; #1;
      chk("async reset req_o", s_req, 1'b0);
      chk("async reset empty_o", s_empty, 1'b1);
      sq.delete(); cq.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      cyc(mk(0, 0, 0, 8'h00, 0, 0, 1, 56'h9000, 8'hFF));
      chk("post-reset req_o", s_req, 1'b0);

      // Depth-4 instance: sustained traffic wraps both pointer sets.
      do_reset(1'b1);
      for (int k = 0; k < 20; k++) begin
         logic [PLEN-1:0] ad;
         case ($urandom_range(0, 2))
            0:       ad = 56'h4000;
            1:       ad = 56'h4004;
            default: ad = 56'h4008;
         endcase
         r = mk(1, ad, {$urandom, $urandom}, 8'($urandom_range(1, 255)),
                ($urandom_range(0, 3) != 0), 0, 1'($urandom_range(0, 1)),
                (k % 2 == 0) ? 56'h4000 : 56'h4008, 8'hFF);
         r.sz = 2'($urandom_range(0, 3));
         cyc(r);
      end
      for (int k = 0; k < 20 && (sq.size() != 0 || cq.size() != 0); k++)
         cyc(mk(0, 0, 0, 8'h00, 1, 0, 1, 56'h4000, 8'hFF));
      chk("wrap drained empty_o", s_empty, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
